bus_trace_checker: RTL and testbench
====================================

Name: bus_trace_checker

Overview:
- Parametrised, self-checking CPU-bus write monitor for simulation harnesses and on-board debug; it sits alongside the cpu/memory pair and snoops cpu_addr, cpu_data_out and cpu_wren.
- In RECORD mode it captures write transactions into a circular trace buffer that can be read back.
- In CHECK mode the same buffer holds a preloaded expected-write FIFO. The block compares each observed write against the FIFO head, counts mismatches and latches the first failure.
- It replaces hand-written per-test error counting with a reusable hardware scoreboard.

Parameters:
- ADDR_W, 16, bus address width
- DATA_W, 8, bus data width
- DEPTH, 32, trace/expected buffer entries; must be a power of two, at least 2
- ERR_W, 8, error counter width

Ports:
- clock  in  1  system clock; all state is updated on the rising edge
- reset  in  1  asynchronous, active-high reset
- arm  in  1  1 = monitor active, 0 = IDLE (buffer contents frozen and readable)
- mode  in  1  0 = RECORD, 1 = CHECK; sampled only on the IDLE->active transition
- clear  in  1  synchronous clear of pointers, count, overflow, err_cnt and first_err; accepted in any state
- bus_addr  in  ADDR_W  snooped CPU address
- bus_data  in  DATA_W  snooped CPU write data
- bus_wren  in  1  snooped CPU write enable
- exp_valid  in  1  push an expected entry
- exp_addr  in  ADDR_W  expected address
- exp_data  in  DATA_W  expected data
- exp_ready  out  1  high when count<DEPTH and state is not RECORD
- trace_rd_idx  in  $clog2(DEPTH)  read index relative to the oldest entry
- trace_rd_addr  out  ADDR_W  entry address; 1-cycle latency
- trace_rd_data  out  DATA_W  entry data; 1-cycle latency
- count  out  $clog2(DEPTH)+1  number of valid entries
- overflow  out  1  sticky; a RECORD write was dropped because the buffer was full
- err_cnt  out  ERR_W  saturating mismatch count
- first_err_valid  out  1  sticky first-error flag
- first_err_addr  out  ADDR_W  bus address of the first error
- first_err_data  out  DATA_W  bus data of the first error
- done  out  1  CHECK state, count==0 and at least one compare since entry
- pass  out  1  done & (err_cnt==0)

Behaviour:
- Reset values:
  - state=IDLE; all pointers, count, err_cnt and wren_q are 0.
  - overflow, first_err_valid, done and pass are 0.
  - trace_rd_* and first_err_addr/data are 0.
  - exp_ready=1.
- Write event = bus_wren & ~wren_q, where wren_q is bus_wren registered every cycle. A write held for N cycles counts once.
  - If arm rises while bus_wren is already high, no event occurs until the next rising edge of bus_wren.
- State machine IDLE/RECORD/CHECK:
  - IDLE & arm & !mode -> RECORD. On entry, clear pointers, count and overflow.
  - IDLE & arm & mode -> CHECK. On entry, clear err_cnt, first_err and the compare flag; preloaded entries are kept.
  - RECORD or CHECK with !arm -> IDLE. Contents are retained.
  - Events are ignored in IDLE and in the transition cycle.
- RECORD:
  - On an event with count<DEPTH: store {bus_addr,bus_data} at wr_ptr, then wr_ptr++ and count++.
  - On an event with count==DEPTH: drop the write and set overflow.
  - Pointers wrap modulo DEPTH.
- Expected push:
  - Accepted when exp_valid & exp_ready, in IDLE or CHECK; the entry is written at wr_ptr.
  - exp_ready is computed from the registered count, so a push is never accepted when full, even if a pop occurs in the same cycle.
- CHECK compare, on an event:
  - count==0: unexpected write, counted as an error.
  - Otherwise: compare bus_addr/bus_data with the head entry. Any difference is an error. The head is popped in both cases (rd_ptr++, count--).
  - A simultaneous push and pop leaves count unchanged and both pointers advance.
- Errors:
  - err_cnt increments by 1 per error and saturates at 2^ERR_W-1.
  - On the first error since entry or clear, first_err_* captures the current bus_addr/bus_data and first_err_valid is set.
- done/pass:
  - Registered outputs, evaluated after the event updates of the same cycle.
  - Both drop to 0 on leaving CHECK or on clear.
- Trace read:
  - trace_rd_* <= buffer[(rd_ptr+trace_rd_idx) mod DEPTH] when trace_rd_idx<count, else 0.
  - The read is registered and is valid in every state.
- clear priority: clear beats a same-cycle event or push, both of which are discarded. The state is unchanged.
- The buffer is inferred RAM with no reset; only pointers and flags reset. A reset mid-transaction returns the block to IDLE with count=0.

Test Plan:
1. RECORD capture: arm=1, mode=0; writes (C000,11), (C001,22), (FF40,91) with bus_wren held 3 cycles each -> count=3, overflow=0, idx0..2 read back (C000,11), (C001,22), (FF40,91).
2. Overflow/wrap (DEPTH=4): 6 writes D0..D5 in RECORD -> count=4, overflow=1, idx0=D0, idx3=D3. Then clear, 2 writes E0,E1 -> count=2, idx0=E0 (pointer wrap exercised).
3. CHECK pass: push (8000,AA), (8001,BB) in IDLE, arm with mode=1, bus writes match -> count=0, err_cnt=0, done=1, pass=1.
4. CHECK mismatch + unexpected: expected (8000,AA), bus writes (8000,AB), then (9000,01) -> err_cnt=2, first_err=(8000,AB), pass=0.
5. Saturation/simultaneity (ERR_W=2): 5 unexpected writes -> err_cnt=3. Push coincident with a matching event at count=1 -> count stays 1, err_cnt unchanged.
6. Async reset asserted mid-RECORD between clock edges -> all outputs zero immediately. After release, a write while arm=0 is ignored (count=0).

Source files
------------

// File: rtl/bus_trace_checker.sv
// CPU-bus write monitor: records write transactions into a circular trace buffer (RECORD)
// or scores them against a preloaded expected-write FIFO (CHECK).
module bus_trace_checker #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 32,
   parameter int ERR_W  = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     arm,
   input  logic                     mode,
   input  logic                     clear,
   input  logic [ADDR_W-1:0]        bus_addr,
   input  logic [DATA_W-1:0]        bus_data,
   input  logic                     bus_wren,
   input  logic                     exp_valid,
   input  logic [ADDR_W-1:0]        exp_addr,
   input  logic [DATA_W-1:0]        exp_data,
   output logic                     exp_ready,
   input  logic [$clog2(DEPTH)-1:0] trace_rd_idx,
   output logic [ADDR_W-1:0]        trace_rd_addr,
   output logic [DATA_W-1:0]        trace_rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [ERR_W-1:0]         err_cnt,
   output logic                     first_err_valid,
   output logic [ADDR_W-1:0]        first_err_addr,
   output logic [DATA_W-1:0]        first_err_data,
   output logic                     done,
   output logic                     pass
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = ADDR_W + DATA_W;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RECORD, S_CHECK} state_t;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_t            state_q, state_d;
   logic              wren_q;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ovf_q, ovf_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic              fe_v_q, fe_v_d;
   logic [ADDR_W-1:0] fe_a_q, fe_a_d;
   logic [DATA_W-1:0] fe_dt_q, fe_dt_d;
   logic              cmp_q, cmp_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [EW-1:0]     trace_q, trace_d;

   logic [EW-1:0]     mem [DEPTH];
   logic              mem_we;
   logic [PW-1:0]     mem_wa;
   logic [EW-1:0]     mem_wd;

   logic              ev, ready, enter_rec, enter_chk, push, pop, err_ev;
   logic [EW-1:0]     head, bus_word;

   // An event is the rising edge of the snooped write enable, only while actively armed.
   assign ev        = bus_wren & ~wren_q & arm & (state_q != S_IDLE);
   assign ready     = (count_q < FULL) && (state_q != S_RECORD);
   assign enter_rec = (state_q == S_IDLE) && arm && !mode;
   assign enter_chk = (state_q == S_IDLE) && arm && mode;
   assign head      = mem[rd_ptr_q];
   assign bus_word  = {bus_addr, bus_data};

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
      fe_v_d   = fe_v_q;
      fe_a_d   = fe_a_q;
      fe_dt_d  = fe_dt_q;
      cmp_d    = cmp_q;
      mem_we   = 1'b0;
      mem_wa   = wr_ptr_q;
      mem_wd   = bus_word;
      push     = 1'b0;
      pop      = 1'b0;
      err_ev   = 1'b0;

      case (state_q)
         S_IDLE:  if (arm) state_d = mode ? S_CHECK : S_RECORD;
         default: if (!arm) state_d = S_IDLE;
      endcase

      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         err_d    = '0;
         fe_v_d   = 1'b0;
         fe_a_d   = '0;
         fe_dt_d  = '0;
         cmp_d    = 1'b0;
      end else begin
         if (enter_rec) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
         end
         if (enter_chk) begin
            err_d   = '0;
            fe_v_d  = 1'b0;
            fe_a_d  = '0;
            fe_dt_d = '0;
            cmp_d   = 1'b0;
         end
         if (ev && state_q == S_RECORD) begin
            if (count_q < FULL) begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               count_d  = count_q + 1'b1;
            end else begin
               ovf_d = 1'b1;
            end
         end
         if (ev && state_q == S_CHECK) begin
            cmp_d = 1'b1;
            if (count_q == '0) begin
               err_ev = 1'b1;
            end else begin
               pop      = 1'b1;
               rd_ptr_d = rd_ptr_q + 1'b1;
               err_ev   = (head != bus_word);
            end
         end
         push = exp_valid && ready && !enter_rec;
         if (push) begin
            mem_we   = 1'b1;
            mem_wd   = {exp_addr, exp_data};
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (push || pop) count_d = count_q + CW'(push) - CW'(pop);
         if (err_ev) begin
            err_d = sat_inc(err_q);
            if (!fe_v_q) begin
               fe_v_d  = 1'b1;
               fe_a_d  = bus_addr;
               fe_dt_d = bus_data;
            end
         end
      end

      done_d  = (state_q == S_CHECK) && (state_d == S_CHECK) && !clear && cmp_d && (count_d == '0);
      pass_d  = done_d && (err_d == '0);
      trace_d = ({1'b0, trace_rd_idx} < count_q) ? mem[rd_ptr_q + trace_rd_idx] : '0;
   end

   // Buffer storage has no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clock) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         wren_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         err_q    <= '0;
         fe_v_q   <= 1'b0;
         fe_a_q   <= '0;
         fe_dt_q  <= '0;
         cmp_q    <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         trace_q  <= '0;
      end else begin
         state_q  <= state_d;
         wren_q   <= bus_wren;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
         fe_v_q   <= fe_v_d;
         fe_a_q   <= fe_a_d;
         fe_dt_q  <= fe_dt_d;
         cmp_q    <= cmp_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         trace_q  <= trace_d;
      end
   end

   assign exp_ready       = ready;
   assign trace_rd_addr   = trace_q[EW-1:DATA_W];
   assign trace_rd_data   = trace_q[DATA_W-1:0];
   assign count           = count_q;
   assign overflow        = ovf_q;
   assign err_cnt         = err_q;
   assign first_err_valid = fe_v_q;
   assign first_err_addr  = fe_a_q;
   assign first_err_data  = fe_dt_q;
   assign done            = done_q;
   assign pass            = pass_q;

endmodule

// File: tb/tb_bus_trace_checker.sv
// Bench for bus_trace_checker (DEPTH=4, ERR_W=2): directed scenarios plus randomized traffic
// scored against a queue-based reference model.
module tb_bus_trace_checker;
   localparam int AW = 16;
   localparam int DW = 8;
   localparam int D  = 4;
   localparam int EW = 2;
   localparam int ERR_MAX = (1 << EW) - 1;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic arm = 1'b0, mode = 1'b0, clear = 1'b0;
   logic [AW-1:0] bus_addr = '0;
   logic [DW-1:0] bus_data = '0;
   logic bus_wren = 1'b0;
   logic exp_valid = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_data = '0;
   logic exp_ready;
   logic [1:0] trace_rd_idx = '0;
   logic [AW-1:0] trace_rd_addr;
   logic [DW-1:0] trace_rd_data;
   logic [2:0] count;
   logic overflow;
   logic [EW-1:0] err_cnt;
   logic first_err_valid;
   logic [AW-1:0] first_err_addr;
   logic [DW-1:0] first_err_data;
   logic done, pass;

   bus_trace_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D), .ERR_W(EW)) dut (
      .clock(clock), .reset(reset), .arm(arm), .mode(mode), .clear(clear),
      .bus_addr(bus_addr), .bus_data(bus_data), .bus_wren(bus_wren),
      .exp_valid(exp_valid), .exp_addr(exp_addr), .exp_data(exp_data), .exp_ready(exp_ready),
      .trace_rd_idx(trace_rd_idx), .trace_rd_addr(trace_rd_addr), .trace_rd_data(trace_rd_data),
      .count(count), .overflow(overflow), .err_cnt(err_cnt),
      .first_err_valid(first_err_valid), .first_err_addr(first_err_addr),
      .first_err_data(first_err_data), .done(done), .pass(pass)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   // Reference model: 0=idle, 1=record, 2=check; the buffer is a plain queue, oldest first.
   logic [AW+DW-1:0] mq[$];
   int m_state, m_err;
   logic m_wprev, m_ovf, m_fev, m_cmp, m_done, m_pass;
   logic [AW-1:0] m_fea;
   logic [DW-1:0] m_fed;
   logic [AW+DW-1:0] m_rd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_state = 0; m_err = 0;
      m_wprev = 0; m_ovf = 0; m_fev = 0; m_cmp = 0; m_done = 0; m_pass = 0;
      m_fea = '0; m_fed = '0; m_rd = '0;
   endtask

   task automatic note_err();
      if (!m_fev) begin
         m_fev = 1; m_fea = bus_addr; m_fed = bus_data;
      end
      if (m_err < ERR_MAX) m_err++;
   endtask

   task automatic model_step();
      logic ev, rdy;
      int nxt;
      logic [AW+DW-1:0] e;
      ev = bus_wren && !m_wprev && arm && (m_state != 0);
      m_wprev = bus_wren;
      rdy = (mq.size() < D) && (m_state != 1);
      m_rd = (int'(trace_rd_idx) < mq.size()) ? mq[trace_rd_idx] : '0;
      if (m_state == 0) nxt = arm ? (mode ? 2 : 1) : 0;
      else nxt = arm ? m_state : 0;
      if (clear) begin
         mq.delete();
         m_ovf = 0; m_err = 0; m_fev = 0; m_fea = '0; m_fed = '0; m_cmp = 0;
      end else begin
         if (m_state == 0 && nxt == 1) begin
            mq.delete(); m_ovf = 0;
         end
         if (m_state == 0 && nxt == 2) begin
            m_err = 0; m_fev = 0; m_fea = '0; m_fed = '0; m_cmp = 0;
         end
         if (ev && m_state == 1) begin
            if (mq.size() < D) mq.push_back({bus_addr, bus_data});
            else m_ovf = 1;
         end
         if (ev && m_state == 2) begin
            m_cmp = 1;
            if (mq.size() == 0) note_err();
            else begin
               e = mq.pop_front();
               if (e != {bus_addr, bus_data}) note_err();
            end
         end
         if (exp_valid && rdy && !(m_state == 0 && nxt == 1)) mq.push_back({exp_addr, exp_data});
      end
      m_done = (m_state == 2) && (nxt == 2) && !clear && m_cmp && (mq.size() == 0);
      m_pass = m_done && (m_err == 0);
      m_state = nxt;
   endtask

   task automatic check_all();
      chk("count", 32'(count), 32'(mq.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      chk("first_err_valid", 32'(first_err_valid), 32'(m_fev));
      chk("first_err_addr", 32'(first_err_addr), 32'(m_fea));
      chk("first_err_data", 32'(first_err_data), 32'(m_fed));
      chk("done", 32'(done), 32'(m_done));
      chk("pass", 32'(pass), 32'(m_pass));
      chk("exp_ready", 32'(exp_ready), 32'((mq.size() < D) && (m_state != 1)));
      chk("trace_rd_addr", 32'(trace_rd_addr), 32'(m_rd[AW+DW-1:DW]));
      chk("trace_rd_data", 32'(trace_rd_data), 32'(m_rd[DW-1:0]));
   endtask

   task automatic cyc();
      model_step();
      @(posedge clock);
      #1;
      check_all();
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
      bus_addr = a; bus_data = d; bus_wren = 1'b1;
      repeat (hold) cyc();
      bus_wren = 1'b0;
      cyc();
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_valid = 1'b1; exp_addr = a; exp_data = d;
      cyc();
      exp_valid = 1'b0;
   endtask

   task automatic rd_expect(input string tag, input logic [1:0] idx, input logic [AW+DW-1:0] want);
      trace_rd_idx = idx;
      cyc();
      chk(tag, 32'({trace_rd_addr, trace_rd_data}), 32'(want));
   endtask

   logic [AW+DW-1:0] t1 [3];

   initial begin
      t1[0] = 24'hC000_11; t1[1] = 24'hC001_22; t1[2] = 24'hFF40_91;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_exp_ready", 32'(exp_ready), 32'd1);
      chk("rst_flags", 32'({overflow, first_err_valid, done, pass}), 32'd0);
      chk("rst_err", 32'(err_cnt), 32'd0);
      chk("rst_trace", 32'({trace_rd_addr, trace_rd_data}), 32'd0);
      reset = 1'b0;

      // 1: RECORD capture with held writes
      arm = 1'b1; mode = 1'b0; cyc();
      for (int i = 0; i < 3; i++) wr(t1[i][23:8], t1[i][7:0], 3);
      chk("t1_count", 32'(count), 32'd3);
      chk("t1_overflow", 32'(overflow), 32'd0);
      arm = 1'b0; cyc();
      for (int i = 0; i < 3; i++) rd_expect("t1_read", 2'(i), t1[i]);

      // 2: overflow, then clear and refill
      arm = 1'b1; cyc();
      for (int i = 0; i < 6; i++) wr(16'hD000 + 16'(i), 8'hD0 + 8'(i), 1);
      chk("t2_count", 32'(count), 32'd4);
      chk("t2_overflow", 32'(overflow), 32'd1);
      rd_expect("t2_idx0", 2'd0, 24'hD000_D0);
      rd_expect("t2_idx3", 2'd3, 24'hD003_D3);
      clear = 1'b1; cyc(); clear = 1'b0;
      wr(16'hE000, 8'hE0, 1); wr(16'hE001, 8'hE1, 1);
      chk("t2_count_after_clear", 32'(count), 32'd2);
      chk("t2_overflow_after_clear", 32'(overflow), 32'd0);
      rd_expect("t2_e0", 2'd0, 24'hE000_E0);

      // 3: CHECK with matching traffic
      arm = 1'b0; clear = 1'b1; cyc(); clear = 1'b0;
      push(16'h8000, 8'hAA); push(16'h8001, 8'hBB);
      mode = 1'b1; arm = 1'b1; cyc();
      wr(16'h8000, 8'hAA, 2); wr(16'h8001, 8'hBB, 2);
      chk("t3_count", 32'(count), 32'd0);
      chk("t3_err", 32'(err_cnt), 32'd0);
      chk("t3_done_pass", 32'({done, pass}), 32'b11);

      // 4: mismatch followed by an unexpected write
      arm = 1'b0; cyc();
      chk("t4_done_drop", 32'({done, pass}), 32'b00);
      push(16'h8000, 8'hAA);
      arm = 1'b1; cyc();
      wr(16'h8000, 8'hAB, 1); wr(16'h9000, 8'h01, 1);
      chk("t4_err", 32'(err_cnt), 32'd2);
      chk("t4_first_err", 32'({first_err_valid, first_err_addr, first_err_data}), 32'h1_8000_AB);
      chk("t4_pass", 32'(pass), 32'd0);

      // 5: saturation, then push coincident with a matching pop
      arm = 1'b0; cyc(); arm = 1'b1; cyc();
      for (int i = 0; i < 5; i++) wr(16'h4000 + 16'(i), 8'(i), 1);
      chk("t5_err_sat", 32'(err_cnt), 32'd3);
      clear = 1'b1; cyc(); clear = 1'b0;
      chk("t5_err_cleared", 32'(err_cnt), 32'd0);
      push(16'h7000, 8'h55);
      exp_valid = 1'b1; exp_addr = 16'h7001; exp_data = 8'h66;
      bus_addr = 16'h7000; bus_data = 8'h55; bus_wren = 1'b1;
      cyc();
      exp_valid = 1'b0; bus_wren = 1'b0; cyc();
      chk("t5_count_same", 32'(count), 32'd1);
      chk("t5_err_same", 32'(err_cnt), 32'd0);
      wr(16'h7001, 8'h66, 1);
      chk("t5_done_pass", 32'({done, pass}), 32'b11);

      // 6: asynchronous reset between edges mid-RECORD
      arm = 1'b0; cyc(); mode = 1'b0; arm = 1'b1; cyc();
      trace_rd_idx = 2'd0;
      wr(16'hA000, 8'h01, 1); wr(16'hA001, 8'h02, 1);
      bus_addr = 16'hA002; bus_wren = 1'b1;
      #2 reset = 1'b1;
      #1;
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_trace", 32'({trace_rd_addr, trace_rd_data}), 32'd0);
      chk("t6_flags", 32'({overflow, first_err_valid, done, pass, err_cnt}), 32'd0);
      chk("t6_exp_ready", 32'(exp_ready), 32'd1);
      bus_wren = 1'b0; arm = 1'b0;
      model_reset();
      @(posedge clock); #1;
      reset = 1'b0;
      wr(16'hB000, 8'h01, 2);
      chk("t6_idle_write", 32'(count), 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 15) == 0) arm = ~arm;
         if (!arm) mode = 1'($urandom_range(0, 1));
         clear = ($urandom_range(0, 59) == 0);
         bus_wren = ($urandom_range(0, 9) < 4);
         if (mq.size() > 0 && $urandom_range(0, 2) != 0) {bus_addr, bus_data} = mq[0];
         else begin
            bus_addr = 16'h8000 | 16'($urandom_range(0, 3));
            bus_data = 8'($urandom_range(0, 3));
         end
         exp_valid = ($urandom_range(0, 3) == 0);
         exp_addr = 16'h8000 | 16'($urandom_range(0, 3));
         exp_data = 8'($urandom_range(0, 3));
         trace_rd_idx = 2'($urandom_range(0, 3));
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
